// File: rtl/baud_gen_frac_if.sv
// Divisor programming port: valid/ready transfer of a new integer+fraction divisor.
// The master offers cfg_div_*; the generator holds cfg_ready low while an update is pending.
`timescale 1ns/1ps
interface baud_gen_frac_if #(
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 4
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DIV_INT_W-1:0]  cfg_div_int;
  logic [DIV_FRAC_W-1:0] cfg_div_frac;

  modport master (output cfg_valid, output cfg_div_int, output cfg_div_frac, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div_int, input cfg_div_frac, output cfg_ready);
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional baud-tick generator: registered 1-cycle Rx (oversample) and Tx (bit) strobes.
// New divisors are accepted into a shadow (cfg_ready drops) and applied on the next Tx bit boundary.
`timescale 1ns/1ps
module baud_gen_frac #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 4
) (
  input  logic                  clk_50m,
  input  logic                  rstn,
  input  logic                  en,
  baud_gen_frac_if.slave        cfg,
  input  logic                  rx_resync,
  output logic                  Rxclk_en,
  output logic                  Txclk_en,
  output logic [DIV_INT_W-1:0]  active_div_int,
  output logic [DIV_FRAC_W-1:0] active_div_frac
);

  localparam int CNT_W = DIV_INT_W + 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam longint unsigned DEN       = longint'(BAUD) * longint'(OVERSAMPLE);
  localparam longint unsigned NUM       = longint'(CLK_HZ) << DIV_FRAC_W;
  localparam longint unsigned DIV_DEF   = (NUM + DEN / 2) / DEN;
  localparam longint unsigned DEF_INT_L = DIV_DEF >> DIV_FRAC_W;

  localparam logic [DIV_INT_W-1:0]  DEF_INT  = DEF_INT_L[DIV_INT_W-1:0];
  localparam logic [DIV_FRAC_W-1:0] DEF_FRAC = DIV_DEF[DIV_FRAC_W-1:0];
  localparam logic [OS_W-1:0]       OS_LAST  = OS_W'(OVERSAMPLE - 1);

  if (OVERSAMPLE < 2) begin : g_bad_os
    $error("baud_gen_frac: OVERSAMPLE must be at least 2");
  end
  if (DEF_INT_L < 2 || DEF_INT_L >= (64'd1 << DIV_INT_W)) begin : g_bad_div
    $error("baud_gen_frac: default divisor integer part out of range");
  end

  // configuration state
  logic [DIV_INT_W-1:0]  active_int_q, active_int_d;
  logic [DIV_FRAC_W-1:0] active_frac_q, active_frac_d;
  logic [DIV_INT_W-1:0]  shd_int_q, shd_int_d;
  logic [DIV_FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic                  pend_q, pend_d;
  logic                  ready_q, ready_d;

  // Tx channel
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [DIV_FRAC_W-1:0] tx_acc_q, tx_acc_d;
  logic [OS_W-1:0]       os_q, os_d;
  logic                  tx_stb_q, tx_stb_d;

  // Rx channel
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [DIV_FRAC_W-1:0] rx_acc_q, rx_acc_d;
  logic                  rx_stb_q, rx_stb_d;
  logic                  rx_pend_q, rx_pend_d;

  logic                  accept;
  logic                  apply;
  logic                  tx_base;
  logic                  tx_wrap;
  logic                  rx_base;
  logic [DIV_INT_W-1:0]  nx_int;
  logic [DIV_FRAC_W-1:0] nx_frac;
  logic [CNT_W-1:0]      nx_first;
  logic [DIV_FRAC_W:0]   tx_add;
  logic [DIV_FRAC_W:0]   rx_add;
  logic [CNT_W-1:0]      tx_step;
  logic [CNT_W-1:0]      rx_step;

  always_comb begin
    accept   = cfg.cfg_valid && ready_q;
    tx_base  = en && (tx_cnt_q == CNT_W'(1));
    tx_wrap  = tx_base && (os_q == OS_LAST);
    rx_base  = en && (rx_cnt_q == CNT_W'(1));
    apply    = pend_q && (!en || tx_wrap);

    // Divisor seen by any reload on this edge, including the one that applies the shadow.
    nx_int   = apply ? shd_int_q  : active_int_q;
    nx_frac  = apply ? shd_frac_q : active_frac_q;
    nx_first = {1'b0, nx_int};

    tx_add   = {1'b0, tx_acc_q} + {1'b0, nx_frac};
    rx_add   = {1'b0, rx_acc_q} + {1'b0, nx_frac};
    tx_step  = nx_first + CNT_W'(tx_add[DIV_FRAC_W]);
    rx_step  = nx_first + CNT_W'(rx_add[DIV_FRAC_W]);

    shd_int_d     = shd_int_q;
    shd_frac_d    = shd_frac_q;
    pend_d        = pend_q;
    ready_d       = ready_q;
    active_int_d  = active_int_q;
    active_frac_d = active_frac_q;

    if (accept) begin
      shd_int_d  = (cfg.cfg_div_int < DIV_INT_W'(2)) ? DIV_INT_W'(2) : cfg.cfg_div_int;
      shd_frac_d = cfg.cfg_div_frac;
      pend_d     = 1'b1;
      ready_d    = 1'b0;
    end else if (!ready_q && !pend_q) begin
      ready_d    = 1'b1;
    end

    if (apply) begin
      active_int_d  = shd_int_q;
      active_frac_d = shd_frac_q;
      pend_d        = 1'b0;
    end

    tx_cnt_d = tx_cnt_q;
    tx_acc_d = tx_acc_q;
    os_d     = os_q;
    tx_stb_d = 1'b0;

    if (!en) begin
      tx_cnt_d = nx_first;
      tx_acc_d = '0;
      os_d     = '0;
    end else if (tx_base) begin
      tx_stb_d = tx_wrap;
      os_d     = tx_wrap ? '0 : os_q + OS_W'(1);
      if (apply) begin
        tx_cnt_d = nx_first;
        tx_acc_d = '0;
      end else begin
        tx_cnt_d = tx_step;
        tx_acc_d = tx_add[DIV_FRAC_W-1:0];
      end
    end else begin
      tx_cnt_d = tx_cnt_q - CNT_W'(1);
    end

    rx_cnt_d  = rx_cnt_q;
    rx_acc_d  = rx_acc_q;
    rx_stb_d  = 1'b0;
    rx_pend_d = rx_pend_q;

    // Resync beats a coincident strobe; a divisor change restarts the fraction at the next reload.
    if (!en || rx_resync) begin
      rx_cnt_d  = nx_first;
      rx_acc_d  = '0;
      rx_pend_d = 1'b0;
    end else if (rx_base) begin
      rx_stb_d  = 1'b1;
      rx_pend_d = 1'b0;
      if (apply || rx_pend_q) begin
        rx_cnt_d = nx_first;
        rx_acc_d = '0;
      end else begin
        rx_cnt_d = rx_step;
        rx_acc_d = rx_add[DIV_FRAC_W-1:0];
      end
    end else begin
      rx_cnt_d  = rx_cnt_q - CNT_W'(1);
      rx_pend_d = rx_pend_q || apply;
    end
  end

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      active_int_q  <= DEF_INT;
      active_frac_q <= DEF_FRAC;
      shd_int_q     <= DEF_INT;
      shd_frac_q    <= DEF_FRAC;
      pend_q        <= 1'b0;
      ready_q       <= 1'b1;
      tx_cnt_q      <= {1'b0, DEF_INT};
      tx_acc_q      <= '0;
      os_q          <= '0;
      tx_stb_q      <= 1'b0;
      rx_cnt_q      <= {1'b0, DEF_INT};
      rx_acc_q      <= '0;
      rx_stb_q      <= 1'b0;
      rx_pend_q     <= 1'b0;
    end else begin
      active_int_q  <= active_int_d;
      active_frac_q <= active_frac_d;
      shd_int_q     <= shd_int_d;
      shd_frac_q    <= shd_frac_d;
      pend_q        <= pend_d;
      ready_q       <= ready_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_acc_q      <= tx_acc_d;
      os_q          <= os_d;
      tx_stb_q      <= tx_stb_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_acc_q      <= rx_acc_d;
      rx_stb_q      <= rx_stb_d;
      rx_pend_q     <= rx_pend_d;
    end
  end

  assign cfg.cfg_ready     = ready_q;
  assign Rxclk_en          = rx_stb_q;
  assign Txclk_en          = tx_stb_q;
  assign active_div_int    = active_int_q;
  assign active_div_frac   = active_frac_q;

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised, runtime-programmable baud-tick generator for the UART blocks on the system bus. It produces single-cycle `Rxclk_en` (oversample) and `Txclk_en` (bit) strobes from a fractional divisor (integer plus `DIV_FRAC_W`-bit fraction), so standard rates are hit without long-term drift. The divisor is reprogrammed through a valid/ready port, and updates take effect only on a bit boundary. An `rx_resync` input lets the receiver re-phase the oversample grid on a start-bit edge.

## Interface
- `CLK_HZ`, 50000000, input clock frequency.
- `BAUD`, 9600, reset/default baud rate.
- `OVERSAMPLE`, 16, Rx strobes per Tx strobe; must be ≥2.
- `DIV_INT_W`, 16, integer divisor width.
- `DIV_FRAC_W`, 4, fractional divisor width.
- `clk_50m  in  1  system clock; the only clock.`
- `rstn  in  1  reset, asynchronous assert, active-low.`
- `en  in  1  generator enable.`
- `cfg_valid  in  1  new divisor offered.`
- `cfg_ready  out  1  divisor port can accept.`
- `cfg_div_int  in  DIV_INT_W  integer clocks per Rx strobe.`
- `cfg_div_frac  in  DIV_FRAC_W  fractional part, in units of 1/2^DIV_FRAC_W.`
- `rx_resync  in  1  restart Rx phase.`
- `Rxclk_en  out  1  one-cycle oversample strobe.`
- `Txclk_en  out  1  one-cycle bit strobe.`
- `active_div_int  out  DIV_INT_W  divisor currently in use.`
- `active_div_frac  out  DIV_FRAC_W  divisor currently in use.`

## Operation
- Default divisor D = round(CLK_HZ·2^DIV_FRAC_W / (BAUD·OVERSAMPLE)), split into an integer part and a fractional part.
  - Elaboration fails if the integer part is <2 or does not fit in `DIV_INT_W`.
  - At 50 MHz / 9600 / 16 this gives int 325, frac 8 (325.5).
- Two identical fractional channels share the active divisor. Each channel has a down-counter `cnt` and an accumulator `acc` of width `DIV_FRAC_W`.
  - On a strobe: `acc <= acc + frac` (mod 2^F).
  - The next period is `div_int+1` if that add overflowed, otherwise `div_int`.
  - After a reload or clear, the first period is always `div_int`.
- Rx channel: every base strobe drives `Rxclk_en`.
- Tx channel: an `os_cnt` counts 0..OVERSAMPLE-1 on its base strobes. `Txclk_en` fires on the base strobe where `os_cnt == OVERSAMPLE-1`.
- Config handshake:
  - Transfer occurs when `cfg_valid && cfg_ready`. The values go into a shadow register and `cfg_ready` drops.
  - The shadow becomes active on the next `Txclk_en` cycle. `cfg_ready` returns high the following cycle.
  - If `en=0`, the shadow is applied the cycle after acceptance.
  - A `cfg_div_int` value <2 is clamped to 2 and is visible on the `active_*` readback.
- Each channel loads the new divisor at its next reload. The Rx channel may finish its current period on the old value.
- `en=0`: both channels are held cleared (`cnt` at first-period start, `acc=0`, `os_cnt=0`) and no strobes are produced.
- `rx_resync` (while `en=1`): clears Rx `cnt`/`acc` to period start. It has no effect on the Tx channel. It is ignored while `en=0`.
- If `rx_resync` and an Rx strobe coincide, resync wins and the strobe is suppressed.

## Timing
- Reset values: `Rxclk_en=0`, `Txclk_en=0`, `cfg_ready=1`, `active_*` = default divisor, all counters cleared.
- Strobes are registered and high for exactly 1 cycle.
- With `en` high from the first edge after reset release, or after `en` rises, the first `Rxclk_en` is high in cycle `div_int`, counting the first enabled edge as cycle 1.
- Strobe spacing equals the period rule above. One Tx bit period is exactly OVERSAMPLE·div_int + (number of carries in those OVERSAMPLE strobes) cycles.
- After `rx_resync` is sampled at edge k, the next `Rxclk_en` is high in cycle k+`div_int`.
- `cfg_ready` is low from the cycle after acceptance through the apply cycle. At most one update is pending at a time.
- Asynchronous reset asserted mid-operation, including with an update pending: all state returns to reset values immediately, and the pending update is discarded.

## Test plan
- Defaults, `en=1` → `Rxclk_en` spacing alternates 325, 326 (starting at 325); `Txclk_en` every 5208 cycles; every strobe is 1 cycle wide.
- Mid-bit, write int 27, frac 2 → `cfg_ready` stays low until the next `Txclk_en`, then goes high. Afterward Rx periods are 27, with one 28 in every 8; Tx period = 434.
- `rx_resync` 100 cycles into an Rx period → next `Rxclk_en` exactly 325 cycles later; Tx strobe spacing unchanged. Resync on a strobe cycle → that strobe is absent.
- Write `cfg_div_int=1` → `active_div_int` reads 2; Rx spacing becomes 2 (or 3 on a carry).
- `en` dropped mid-period for 50 cycles → no strobes while low; first `Rxclk_en` 325 cycles after re-enable; `os_cnt` restarted (the next Tx strobe comes after 16 Rx strobes).
- `rstn` pulsed while an update is pending → `cfg_ready=1`, `active` returns to 325/8, strobes restart from the cleared state.
